wb_queue: RTL and testbench

Writeback queue feeding the register file's single write port. Accepts register-write requests from two producers, the ALU result path and the data-memory load-return path, buffers them in order, and retires one per cycle onto the register file's `wr_en`/`wr_addr`/`dat_in` inputs. It lets a load return and an ALU result land in the same cycle without either being lost. It also reports queue occupancy to the decode/stall logic.

---
 rtl/wb_queue.sv | 123 ++++++++++++
 tb/tb_wb_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue merging ALU results and load returns
// onto the register file's single write port, one retirement per cycle.
// Optional feature macro: WB_PENDING_EN builds the per-register
// outstanding-write bitmap on 'pending'; without it 'pending' is all zeros.
module wb_queue #(
  parameter int pw    = 4,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic [pw-1:0]              mem_addr,
  input  logic [7:0]                 mem_data,
  output logic                       mem_ready,
  input  logic                       alu_valid,
  input  logic [pw-1:0]              alu_addr,
  input  logic [7:0]                 alu_data,
  output logic                       alu_ready,
  output logic                       wr_en,
  output logic [pw-1:0]              wr_addr,
  output logic [7:0]                 dat_in,
  output logic [$clog2(depth):0]     count,
  output logic                       busy,
  output logic [(2**pw)-1:0]         pending
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [pw-1:0] r_addr [depth];
  logic [7:0]    r_data [depth];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_wrEn;
  logic [pw-1:0] r_wrAddr;
  logic [7:0]    r_datIn;

  logic          w_memPush;
  logic          w_aluPush;
  logic          w_pop;
  logic [AW-1:0] w_aluSlot;

  // Readies look only at registered occupancy; the ALU needs two free slots
  // when a load return is competing for the same edge.
  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (!reset) begin
      mem_ready = (r_count < CW'(depth));
      alu_ready = mem_valid ? (r_count <= CW'(depth - 2)) : (r_count < CW'(depth));
    end
  end

  assign w_memPush = mem_valid & mem_ready;
  assign w_aluPush = alu_valid & alu_ready;
  assign w_pop     = (r_count != '0);
  assign w_aluSlot = r_wrPtr + AW'(w_memPush);

  // Entry storage: the load return takes the tail slot first, the ALU result the next one.
  always_ff @(posedge clk) begin
    if (w_memPush) begin
      r_addr[r_wrPtr] <= mem_addr;
      r_data[r_wrPtr] <= mem_data;
    end
    if (w_aluPush) begin
      r_addr[w_aluSlot] <= alu_addr;
      r_data[w_aluSlot] <= alu_data;
    end
  end

  // Pointers, occupancy and the registered write-port stage; reset discards all entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_datIn  <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + AW'(w_memPush) + AW'(w_aluPush);
      r_count <= r_count + CW'(w_memPush) + CW'(w_aluPush) - CW'(w_pop);
      if (w_pop) begin
        r_wrEn   <= 1'b1;
        r_wrAddr <= r_addr[r_rdPtr];
        r_datIn  <= r_data[r_rdPtr];
        r_rdPtr  <= r_rdPtr + AW'(1);
      end else begin
        r_wrEn <= 1'b0;
      end
    end
  end

  assign wr_en   = r_wrEn;
  assign wr_addr = r_wrAddr;
  assign dat_in  = r_datIn;
  assign count   = r_count;
  assign busy    = (r_count != '0) | r_wrEn;

`ifdef WB_PENDING_EN
  logic [(2**pw)-1:0] w_pending;

  // A slot is live when its distance from the head is below the occupancy;
  // the entry sitting in the output stage still counts until it is written.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < depth; i++) begin
      if ({1'b0, AW'(i) - r_rdPtr} < r_count) begin
        w_pending[r_addr[i]] = 1'b1;
      end
    end
    if (r_wrEn) begin
      w_pending[r_wrAddr] = 1'b1;
    end
  end

  assign pending = w_pending;
`else
  assign pending = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed vector table plus hand sequences for reset,
// pending bitmap and a continuous-backpressure scoreboard run.
module tb_wb_queue;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [7:0]  alu_data;
  logic        alu_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  dat_in;
  logic [2:0]  count;
  logic        busy;
  logic [15:0] pending;

  int compared = 0;
  int mismatched = 0;

  wb_queue #(.pw(4), .depth(4)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .count(count), .busy(busy), .pending(pending)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       rst;
    logic       mv;
    logic [3:0] ma;
    logic [7:0] md;
    logic       av;
    logic [3:0] aa;
    logic [7:0] ad;
    logic       eMr;
    logic       eAr;
    logic       eWe;
    logic [3:0] eWa;
    logic [7:0] eD;
    logic [2:0] eCnt;
    logic       eBusy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic mv, logic [3:0] ma, logic [7:0] md,
                              logic av, logic [3:0] aa, logic [7:0] ad,
                              logic eMr, logic eAr, logic eWe, logic [3:0] eWa,
                              logic [7:0] eD, logic [2:0] eCnt, logic eBusy);
    vec_t v;
    v.rst = rst; v.mv = mv; v.ma = ma; v.md = md;
    v.av = av; v.aa = aa; v.ad = ad;
    v.eMr = eMr; v.eAr = eAr; v.eWe = eWe; v.eWa = eWa;
    v.eD = eD; v.eCnt = eCnt; v.eBusy = eBusy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic mv, input logic [3:0] ma,
                               input logic [7:0] md, input logic av, input logic [3:0] aa,
                               input logic [7:0] ad);
    @(negedge clk);
    reset     = rst;
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    #1;
  endtask

  // Bench-side model state for the backpressure run.
  int         mcount;
  logic [11:0] mq[$];
  logic [11:0] expEntry;
  logic       eMr, eAr, memX, aluX, popExp, aluDone;
  logic [3:0] curMa, curAa;
  logic [7:0] curMd, curAd;
  logic [15:0] expPend;

  // Main sequence: reset, vector table, pending check, scoreboard run.
  initial begin
    reset = 1'b1;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;

    // Reset held for two edges with both valids low.
    @(posedge clk); #1;
    checkOutput("rst_mem_ready_low", {31'b0, mem_ready}, 32'd0);
    checkOutput("rst_alu_ready_low", {31'b0, alu_ready}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    checkOutput("rst_wr_en", {31'b0, wr_en}, 32'd0);
    checkOutput("rst_count", {29'b0, count}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
    checkOutput("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    checkOutput("rst_pending", {16'b0, pending}, 32'd0);

    //        rst mv  ma    md     av  aa    ad     eMr eAr eWe eWa   eD     cnt busy
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 4'h0, 8'h00, 0, 0));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 1, 4'h3, 8'h5A, 1, 1, 0, 4'h0, 8'h00, 1, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 1, 4'h3, 8'h5A, 0, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 4'h3, 8'h5A, 0, 0));
    vq.push_back(mk(0, 1, 4'h2, 8'h11, 1, 4'h2, 8'h22, 1, 1, 0, 4'h3, 8'h5A, 2, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 1, 4'h2, 8'h11, 1, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 1, 4'h2, 8'h22, 0, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 4'h2, 8'h22, 0, 0));
    vq.push_back(mk(0, 1, 4'h0, 8'h33, 0, 4'h0, 8'h00, 1, 1, 0, 4'h2, 8'h22, 1, 1));
    vq.push_back(mk(0, 1, 4'h7, 8'h44, 1, 4'h8, 8'h55, 1, 1, 1, 4'h0, 8'h33, 2, 1));
    vq.push_back(mk(0, 1, 4'h9, 8'h66, 1, 4'hA, 8'h77, 1, 1, 1, 4'h7, 8'h44, 3, 1));
    vq.push_back(mk(0, 1, 4'hB, 8'h88, 1, 4'hC, 8'h99, 1, 0, 1, 4'h8, 8'h55, 3, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 1, 4'hC, 8'h99, 1, 1, 1, 4'h9, 8'h66, 3, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 1, 4'hA, 8'h77, 2, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 1, 4'hB, 8'h88, 1, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 1, 4'hC, 8'h99, 0, 1));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 4'hC, 8'h99, 0, 0));
    vq.push_back(mk(0, 1, 4'hD, 8'hA1, 1, 4'hE, 8'hA2, 1, 1, 0, 4'hC, 8'h99, 2, 1));
    vq.push_back(mk(0, 1, 4'hF, 8'hA3, 1, 4'h1, 8'hA4, 1, 1, 1, 4'hD, 8'hA1, 3, 1));
    vq.push_back(mk(1, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 0, 0));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 4'h0, 8'h00, 0, 0));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 4'h0, 8'h00, 0, 0));
    vq.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 4'h0, 8'h00, 0, 0));

    foreach (vq[i]) begin
      applyStimulus(vq[i].rst, vq[i].mv, vq[i].ma, vq[i].md, vq[i].av, vq[i].aa, vq[i].ad);
      checkOutput($sformatf("v%0d_mem_ready", i), {31'b0, mem_ready}, {31'b0, vq[i].eMr});
      checkOutput($sformatf("v%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, vq[i].eAr});
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_wr_en", i), {31'b0, wr_en}, {31'b0, vq[i].eWe});
      checkOutput($sformatf("v%0d_wr_addr", i), {28'b0, wr_addr}, {28'b0, vq[i].eWa});
      checkOutput($sformatf("v%0d_dat_in", i), {24'b0, dat_in}, {24'b0, vq[i].eD});
      checkOutput($sformatf("v%0d_count", i), {29'b0, count}, {29'b0, vq[i].eCnt});
      checkOutput($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vq[i].eBusy});
    end

    // Pending bitmap for a single ALU write to r5.
`ifdef WB_PENDING_EN
    expPend = 16'h0020;
`else
    expPend = 16'h0000;
`endif
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 8'h3C);
    @(posedge clk); #1;
    checkOutput("pend_edge0", {16'b0, pending}, {16'b0, expPend});
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
    checkOutput("pend_edge1", {16'b0, pending}, {16'b0, expPend});
    checkOutput("pend_wr_data", {24'b0, dat_in}, 32'h3C);
    @(posedge clk); #1;
    checkOutput("pend_edge2", {16'b0, pending}, 32'd0);
    checkOutput("pend_wr_en_off", {31'b0, wr_en}, 32'd0);

    // Both sources valid every cycle, checked against a queue model.
    mcount = 0;
    aluDone = 1'b0;
    curMa = 4'h1; curMd = 8'h10;
    curAa = 4'h8; curAd = 8'h80;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (aluDone && mcount == 0) break;
      applyStimulus(1'b0, (cyc < 12), curMa, curMd, !aluDone, curAa, curAd);
      eMr = (mcount < 4);
      eAr = mem_valid ? (mcount <= 2) : (mcount < 4);
      checkOutput($sformatf("bp%0d_mem_ready", cyc), {31'b0, mem_ready}, {31'b0, eMr});
      checkOutput($sformatf("bp%0d_alu_ready", cyc), {31'b0, alu_ready}, {31'b0, eAr});
      memX = mem_valid && eMr;
      aluX = alu_valid && eAr;
      popExp = (mcount > 0);
      expEntry = '0;
      if (popExp) expEntry = mq.pop_front();
      if (memX) mq.push_back({curMa, curMd});
      if (aluX) mq.push_back({curAa, curAd});
      mcount = mcount + int'(memX) + int'(aluX) - int'(popExp);
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_wr_en", cyc), {31'b0, wr_en}, {31'b0, popExp});
      if (popExp) begin
        checkOutput($sformatf("bp%0d_retired", cyc), {20'b0, wr_addr, dat_in}, {20'b0, expEntry});
      end
      checkOutput($sformatf("bp%0d_count", cyc), {29'b0, count}, mcount);
      if (memX) begin
        curMa = curMa + 4'h1;
        curMd = curMd + 8'h03;
      end
      if (aluX) begin
        curAa = curAa + 4'h1;
        curAd = curAd + 8'h05;
        if (cyc >= 12) aluDone = 1'b1;
      end
    end
    checkOutput("bp_drained", {31'b0, (aluDone && mcount == 0)}, 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
    checkOutput("bp_final_busy", {31'b0, busy}, 32'd0);
    checkOutput("bp_final_count", {29'b0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
